// File: rtl/fp_regfile_read_port.sv
// Two-operand read stage for the FPU register bank: storage, one writeback port,
// and a registered output stage with write bypass. Optional macro: FPU_REG0_ZERO_EN.
module fp_regfile_read_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs,
    input  logic [ADDR_W-1:0] req_rt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ADDR_W-1:0] out_rs,
    output logic [ADDR_W-1:0] out_rt
);
    localparam int DEPTH = 1 << ADDR_W;

    // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
    // operands are consumed on a rising edge where out_valid && out_ready.
    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr_hit;
    logic              accept;
    logic              hold;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;
    assign hold      = out_valid && !out_ready;

    always_comb begin
        wr_hit = wr_en;
`ifdef FPU_REG0_ZERO_EN
        // Index 0 is constant zero: a write to it is dropped everywhere.
        wr_hit = wr_en && (wr_addr != '0);
`endif
        rd_a = (wr_hit && wr_addr == req_rs) ? wr_data : regs[req_rs];
        rd_b = (wr_hit && wr_addr == req_rt) ? wr_data : regs[req_rt];
`ifdef FPU_REG0_ZERO_EN
        if (req_rs == '0) rd_a = '0;
        if (req_rt == '0) rd_b = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_hit) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_rs    <= '0;
            out_rt    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_a     <= rd_a;
            out_b     <= rd_b;
            out_rs    <= req_rs;
            out_rt    <= req_rt;
        end else if (hold) begin
            // Held operands track writeback so the consumer never sees stale data.
            if (wr_hit && wr_addr == out_rs) out_a <= wr_data;
            if (wr_hit && wr_addr == out_rt) out_b <= wr_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fp_regfile_read_port.sv
// Directed bench for fp_regfile_read_port: expected operands are queued at request
// time and a monitor compares them whenever the output stage hands off.
module tb_fp_regfile_read_port;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 2 * DW + 2 * AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_rs = '0;
    logic [AW-1:0] req_rt = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_a;
    logic [DW-1:0] out_b;
    logic [AW-1:0] out_rs;
    logic [AW-1:0] out_rt;

    logic [EW-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

`ifdef FPU_REG0_ZERO_EN
    localparam logic [DW-1:0] R0_FIRST  = 32'h0000_0000;
    localparam logic [DW-1:0] R0_BYPASS = 32'h0000_0000;
`else
    localparam logic [DW-1:0] R0_FIRST  = 32'h1234_5678;
    localparam logic [DW-1:0] R0_BYPASS = 32'hDEAD_BEEF;
`endif

    fp_regfile_read_port #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs(req_rs), .req_rt(req_rt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_rs(out_rs), .out_rt(out_rt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
    endtask

    task automatic req(input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        req_valid = 1'b1; req_rs = rs; req_rt = rt;
    endtask

    task automatic expect_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [AW-1:0] rs, input logic [AW-1:0] rt);
        exp_q.push_back({a, b, rs, rt});
    endtask

    task automatic idle();
        wr_en = 1'b0; req_valid = 1'b0;
    endtask

    // Monitor: every handoff must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 80'({out_a, out_b, out_rs, out_rt}), 80'd0);
                if ({out_a, out_b, out_rs, out_rt} == '0) begin
                    errors++;
                    $display("FAIL unexpected_output: got handoff expected none");
                end
            end else begin
                check("operands", 80'({out_a, out_b, out_rs, out_rt}), 80'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        logic [DW-1:0] vals [4];
        vals[0] = 32'h3F00_0000; vals[1] = 32'h40A0_0000;
        vals[2] = 32'hC120_0000; vals[3] = 32'h7F7F_FFFF;

        // Reset state
        #3;
        check("reset_out_valid", 80'(out_valid), 80'd0);
        check("reset_outputs", 80'({out_a, out_b, out_rs, out_rt}), 80'd0);
        check("reset_req_ready", 80'(req_ready), 80'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Write then read, including an unwritten register
        cycle(); wr(5, 32'h3F80_0000);
        cycle(); wr_en = 1'b0; req(5, 0); expect_op(32'h3F80_0000, 32'h0, 5, 0);
        cycle(); idle();
        check("latency_out_valid", 80'(out_valid), 80'd1);

        // Same-cycle write bypass to both operands
        cycle(); wr(7, 32'h4049_0FDB); req(7, 7); expect_op(32'h4049_0FDB, 32'h4049_0FDB, 7, 7);
        cycle(); idle();
        cycle();

        // Hold under backpressure with refresh of operand A
        out_ready = 1'b0; req(3, 5); expect_op(32'hC000_0000, 32'h3F80_0000, 3, 5);
        cycle(); req(1, 1); wr(3, 32'hC000_0000);
        #1;
        check("hold_req_ready", 80'(req_ready), 80'd0);
        check("hold_out_valid", 80'(out_valid), 80'd1);
        check("hold_before_refresh", 80'({out_a, out_rs}), 80'({32'h0, 5'd3}));
        cycle(); wr_en = 1'b0;
        #1;
        check("hold_after_refresh", 80'(out_a), 80'(32'hC000_0000));
        check("hold_still_valid", 80'(out_valid), 80'd1);
        check("hold_still_blocked", 80'(req_ready), 80'd0);
        cycle(); req_valid = 1'b0; out_ready = 1'b1;
        cycle();
        check("hold_no_extra_accept", 80'(out_valid), 80'd0);

        // Back-to-back requests
        for (int i = 0; i < 4; i++) begin
            wr(AW'(10 + i), vals[i]);
            cycle();
        end
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b0; req(AW'(10 + i), AW'(13 - i));
            expect_op(vals[i], vals[3-i], AW'(10 + i), AW'(13 - i));
            #1;
            check("b2b_req_ready", 80'(req_ready), 80'd1);
            if (i > 0) check("b2b_out_valid", 80'(out_valid), 80'd1);
            cycle();
        end
        idle();
        #1 check("b2b_last_valid", 80'(out_valid), 80'd1);
        cycle();
        check("b2b_drained", 80'(out_valid), 80'd0);

        // Register 0 behaviour
        wr(0, 32'h1234_5678);
        cycle(); wr_en = 1'b0; req(0, 0); expect_op(R0_FIRST, R0_FIRST, 0, 0);
        cycle(); wr(0, 32'hDEAD_BEEF); req(0, 5); expect_op(R0_BYPASS, 32'h3F80_0000, 0, 5);
        cycle(); idle();
        cycle();

        // Reset during a held transaction
        out_ready = 1'b0; req(7, 7);
        cycle(); idle();
        check("pre_reset_valid", 80'(out_valid), 80'd1);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 80'(out_valid), 80'd0);
        check("midreset_outputs", 80'({out_a, out_b, out_rs, out_rt}), 80'd0);
        check("midreset_req_ready", 80'(req_ready), 80'd1);
        cycle(); cycle();
        rst_n = 1'b1; out_ready = 1'b1;
        cycle(); req(7, 10); expect_op(32'h0, 32'h0, 7, 10);
        cycle(); req(5, 3); expect_op(32'h0, 32'h0, 5, 3);
        cycle(); idle();

        // Bounded drain of outstanding expectations
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle();
        check("queue_drained", 80'(exp_q.size()), 80'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_regfile_read_port.md
# fp_regfile_read_port

Two-operand read stage for the 32-entry, 32-bit FPU register bank. It owns the storage array and a single write port from writeback. It accepts operand-fetch requests under a valid/ready handshake and returns both operands one cycle later in a registered output stage that holds its data under backpressure. Write-to-read bypass keeps returned and held operands coherent with writeback. It sits between decode (request side) and the FPU datapath (response side).

## Interface
- DATA_W, 32, register and operand width
- ADDR_W, 5, register address width (32 entries)
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  writeback write enable
- wr_addr  input  ADDR_W  writeback register index
- wr_data  input  DATA_W  writeback data
- req_valid  input  1  read request present
- req_ready  output  1  request accepted this cycle when high with req_valid
- req_rs  input  ADDR_W  operand A index
- req_rt  input  ADDR_W  operand B index
- out_valid  output  1  operands valid
- out_ready  input  1  consumer takes operands this cycle
- out_a  output  DATA_W  operand A
- out_b  output  DATA_W  operand B
- out_rs, out_rt  output  ADDR_W  indices of the held operands

## Operation
- Storage: 32 x DATA_W flops; write at rising edge when wr_en, to wr_addr.
- req_ready = !out_valid || out_ready (combinational; one-entry output stage, no skid).
- Accept (req_valid && req_ready): next edge loads out_a/out_b with the read of req_rs/req_rt, captures indices, sets out_valid.
- Bypass on accept: if wr_en and wr_addr == req_rs, out_a takes wr_data instead of array value; same for rt/out_b. Both may hit the same write.
- Hold: when out_valid && !out_ready, outputs stay stable except for refresh: wr_en with wr_addr == out_rs updates out_a to wr_data; likewise out_rt/out_b.
- Drain: out_valid && out_ready with no accept clears out_valid next edge; with accept, the stage reloads (back-to-back, one per cycle).
- Outputs only change at clock edges; no combinational path from wr_* to out_*.

## Timing
- Reset (async, immediate): array all zero; out_valid=0, out_a=out_b=0, out_rs=out_rt=0; req_ready=1 while in reset deassertion.
- Read latency: 1 cycle from accept edge to out_valid.
- Write visibility: write at edge N is visible to a request accepted at edge N (bypass) and all later.
- Throughput: one request per cycle while out_ready stays high.
- Reset asserted mid-transaction: pending output discarded, out_valid drops immediately.

## Configuration
- FPU_REG0_ZERO_EN defined: index 0 is hardwired zero; writes to 0 ignored (no array update, no bypass, no refresh); reads of 0 return 0.
- Undefined: index 0 is an ordinary writable register with full bypass and refresh.

## Test plan
- Reset, write 0x3F800000 to reg 5, then request rs=5, rt=0 -> next cycle out_valid=1, out_a=0x3F800000, out_b=0.
- Same-cycle write reg 7=0x40490FDB with request rs=7, rt=7 -> out_a=out_b=0x40490FDB.
- Hold out_ready=0 with out_rs=3; write reg 3=0xC0000000 -> out_a becomes 0xC0000000, out_valid stays 1, req_ready=0; new request not accepted.
- Four back-to-back requests with out_ready=1 -> out_valid high four consecutive cycles, correct data each cycle, req_ready never low.
- With FPU_REG0_ZERO_EN: write 0x12345678 to reg 0, read rs=0 -> 0; without macro -> 0x12345678.
- Assert rst_n low while out_valid=1 -> out_valid=0 and outputs zero before next edge; subsequent read of any register returns 0.
